// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART TX arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   // Watchdog counter width: must be able to hold STALL_LIMIT itself.
   function automatic int stall_cnt_w(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set bit of valid at or after ptr, wrapping at N-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 any,
   output logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] idx
);

   localparam int            IW   = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] cand;

   // Walk the ring starting at ptr; wrap explicitly so non-power-of-two N works.
   always_comb begin
      any    = 1'b0;
      onehot = '0;
      idx    = '0;
      cand   = ptr;
      for (int i = 0; i < N; i++) begin
         if (!any && valid[cand]) begin
            any         = 1'b1;
            idx         = cand;
            onehot[cand] = 1'b1;
         end
         cand = (cand == LAST) ? '0 : cand + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the uart_core TX write port among NUM_REQ byte streams, round-robin per packet, with a stall watchdog.
// Latency: one IDLE cycle to grant; accepted byte appears on wdata_o/wdata_we_o one cycle after the handshake.
// Backpressure: owner's ready follows !tx_fifo_full_i combinationally; non-owners always see ready low.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int STALL_LIMIT = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
   input  logic [NUM_REQ-1:0]         req_last_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic                       tx_fifo_full_i,
   output logic [DATA_W-1:0]          wdata_o,
   output logic                       wdata_we_o,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic                       busy_o,
   output logic                       stall_err_o,
   output logic [$clog2(NUM_REQ)-1:0] stall_src_o,
   input  logic                       stall_clr_i
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               CNT_W    = stall_cnt_w(STALL_LIMIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_LIMIT - 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

   arb_state_t       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] owner_next;
   logic [CNT_W-1:0] stall_cnt;

   logic               pick_any;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;

   logic              own_valid;
   logic              own_last;
   logic [DATA_W-1:0] own_data;
   logic              xfer;
   logic              stall_hit;

   uart_rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .valid  (req_valid_i),
      .ptr    (rr_ptr),
      .any    (pick_any),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // Select the owner's lane and decide whether a byte moves this cycle.
   always_comb begin
      own_valid   = req_valid_i[owner];
      own_last    = req_last_i[owner];
      own_data    = req_data_i[owner*DATA_W +: DATA_W];
      owner_next  = (owner == IDX_MAX) ? '0 : owner + 1'b1;
      xfer        = (state == ARB_LOCK) && own_valid && !tx_fifo_full_i;
      stall_hit   = (stall_cnt >= CNT_LAST);
      req_ready_o = ((state == ARB_LOCK) && !tx_fifo_full_i) ? grant_o : '0;
   end

   // Arbitration FSM with registered grant, write strobe/data and watchdog state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ARB_IDLE;
         owner       <= '0;
         rr_ptr      <= '0;
         stall_cnt   <= '0;
         grant_o     <= '0;
         busy_o      <= 1'b0;
         wdata_o     <= '0;
         wdata_we_o  <= 1'b0;
         stall_err_o <= 1'b0;
         stall_src_o <= '0;
      end else begin
         wdata_we_o <= 1'b0;
         // A same-cycle abort below overrides this clear.
         if (stall_clr_i) begin
            stall_err_o <= 1'b0;
         end
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  state     <= ARB_LOCK;
                  owner     <= pick_idx;
                  grant_o   <= pick_onehot;
                  busy_o    <= 1'b1;
                  stall_cnt <= '0;
               end
            end
            ARB_LOCK: begin
               if (xfer) begin
                  wdata_o    <= own_data;
                  wdata_we_o <= 1'b1;
                  stall_cnt  <= '0;
                  if (own_last) begin
                     state   <= ARB_IDLE;
                     grant_o <= '0;
                     busy_o  <= 1'b0;
                     rr_ptr  <= owner_next;
                  end
               end else if (stall_hit) begin
                  // Owner made no progress for the whole window: drop the lock.
                  state       <= ARB_IDLE;
                  grant_o     <= '0;
                  busy_o      <= 1'b0;
                  rr_ptr      <= owner_next;
                  stall_err_o <= 1'b1;
                  stall_src_o <= owner;
               end else begin
                  // stall_hit stops the count before it can exceed CNT_LAST.
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized run.
// Latency: the reference model expects grant one cycle after an IDLE pick and strobe one cycle after a handshake.
// Backpressure: tx_fifo_full_i and per-requester valid gaps are driven by the scenarios.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int SL   = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        full;
   logic [7:0]  wdata;
   logic        we;
   logic [3:0]  grant;
   logic        busy;
   logic        err;
   logic [1:0]  src;
   logic        clr;

   uart_tx_arbiter #(
      .NUM_REQ     (NREQ),
      .DATA_W      (8),
      .STALL_LIMIT (SL)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid),
      .req_data_i     (req_data),
      .req_last_i     (req_last),
      .req_ready_o    (req_ready),
      .tx_fifo_full_i (full),
      .wdata_o        (wdata),
      .wdata_we_o     (we),
      .grant_o        (grant),
      .busy_o         (busy),
      .stall_err_o    (err),
      .stall_src_o    (src),
      .stall_clr_i    (clr)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   // Requester-side packet queues: {last, byte}; hold forces valid low.
   logic [8:0] pq[4][$];
   bit         hold[4];
   logic [7:0] wr_q[$];

   // Reference model state.
   logic [3:0] exp_grant;
   bit         exp_we;
   logic [7:0] exp_byte;
   bit         exp_err;
   logic [1:0] exp_src;
   int         mptr;
   int         nop;

   // Samples from the most recent step.
   logic [3:0] s_grant, s_ready;
   logic       s_we, s_busy, s_err;
   logic [7:0] s_wdata;
   logic [1:0] s_src;

   function automatic logic [3:0] pick(input logic [3:0] v, input int p);
      int k;
      for (int i = 0; i < 4; i++) begin
         k = (p + i) % 4;
         if (v[k]) return 4'b0001 << k;
      end
      return 4'b0000;
   endfunction

   task automatic model_reset();
      exp_grant = 4'b0;
      exp_we    = 1'b0;
      exp_byte  = 8'h00;
      exp_err   = 1'b0;
      exp_src   = 2'd0;
      mptr      = 0;
      nop       = 0;
   endtask

   task automatic push_byte(input int r, input logic [7:0] b, input bit l);
      pq[r].push_back({l, b});
   endtask

   task automatic drive();
      for (int r = 0; r < 4; r++) begin
         req_valid[r]         = (pq[r].size() != 0) && !hold[r];
         req_data[r*8 +: 8]   = (pq[r].size() != 0) ? pq[r][0][7:0] : 8'h00;
         req_last[r]          = (pq[r].size() != 0) ? pq[r][0][8] : 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      full  = 1'b0;
      clr   = 1'b0;
      for (int r = 0; r < 4; r++) begin
         hold[r] = 1'b0;
         pq[r].delete();
      end
      wr_q.delete();
      drive();
      repeat (2) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      model_reset();
   endtask

   // One clock of stimulus plus comparison of every output against the model.
   task automatic step();
      logic [3:0] exp_ready;
      logic [3:0] hs;
      int         g;
      bit         abort;
      drive();
      #1;
      exp_ready = (exp_grant != 4'b0 && !full) ? exp_grant : 4'b0;
      s_grant = grant; s_busy = busy; s_we = we; s_wdata = wdata;
      s_ready = req_ready; s_err = err; s_src = src;
      checks++; if (grant !== exp_grant) $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, exp_grant); else passed++;
      checks++; if (busy !== (exp_grant != 4'b0)) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_grant != 4'b0); else passed++;
      checks++; if (req_ready !== exp_ready) $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); else passed++;
      checks++; if (we !== exp_we) $display("FAIL wdata_we cyc=%0d got=%b exp=%b", cyc, we, exp_we); else passed++;
      checks++; if (wdata !== exp_byte) $display("FAIL wdata cyc=%0d got=%h exp=%h", cyc, wdata, exp_byte); else passed++;
      checks++; if (err !== exp_err) $display("FAIL stall_err cyc=%0d got=%b exp=%b", cyc, err, exp_err); else passed++;
      checks++; if (src !== exp_src) $display("FAIL stall_src cyc=%0d got=%0d exp=%0d", cyc, src, exp_src); else passed++;
      if (we === 1'b1) wr_q.push_back(wdata);

      hs = req_valid & exp_ready;
      g  = 0;
      for (int r = 0; r < 4; r++) if (exp_grant[r]) g = r;
      abort  = 1'b0;
      exp_we = (hs != 4'b0);
      if (exp_grant == 4'b0) begin
         nop       = 0;
         exp_grant = pick(req_valid, mptr);
      end else if (hs != 4'b0) begin
         exp_byte = req_data[g*8 +: 8];
         nop      = 0;
         if (req_last[g]) begin
            exp_grant = 4'b0;
            mptr      = (g + 1) % 4;
         end
      end else begin
         nop++;
         if (nop >= SL) begin
            abort     = 1'b1;
            exp_grant = 4'b0;
            mptr      = (g + 1) % 4;
            exp_err   = 1'b1;
            exp_src   = 2'(g);
         end
      end
      if (clr && !abort) exp_err = 1'b0;
      if (hs != 4'b0) void'(pq[g].pop_front());
      @(posedge clk_i);
      #2;
      cyc++;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      req_valid = 4'hF; req_last = 4'hF; req_data = 32'hA5A5_A5A5;
      full = 1'b0; clr = 1'b0;
      @(posedge clk_i);
      #2;
      checks++; if (grant !== 4'b0) $display("FAIL rst_grant got=%b exp=0", grant); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
      checks++; if (we !== 1'b0) $display("FAIL rst_we got=%b exp=0", we); else passed++;
      checks++; if (wdata !== 8'h00) $display("FAIL rst_wdata got=%h exp=00", wdata); else passed++;
      checks++; if (req_ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0", req_ready); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else passed++;
      checks++; if (src !== 2'd0) $display("FAIL rst_src got=%0d exp=0", src); else passed++;
      do_reset();
   endtask

   task automatic test_single_packet();
      logic [7:0] exp_b[3];
      int         wc[$];
      logic [7:0] wb[$];
      exp_b[0] = 8'h55; exp_b[1] = 8'hAA; exp_b[2] = 8'h0F;
      do_reset();
      for (int i = 0; i < 3; i++) push_byte(0, exp_b[i], i == 2);
      for (int i = 0; i < 8; i++) begin
         step();
         if (s_we === 1'b1) begin
            wc.push_back(i);
            wb.push_back(s_wdata);
         end
      end
      checks++; if (wc.size() != 3) $display("FAIL single_count got=%0d exp=3", wc.size()); else passed++;
      for (int i = 0; i < 3 && i < wc.size(); i++) begin
         checks++; if (wc[i] != i + 2) $display("FAIL single_cycle%0d got=%0d exp=%0d", i, wc[i], i + 2); else passed++;
         checks++; if (wb[i] !== exp_b[i]) $display("FAIL single_byte%0d got=%h exp=%h", i, wb[i], exp_b[i]); else passed++;
      end
   endtask

   task automatic test_rr_order();
      logic [3:0] own[$];
      int         st[$];
      logic [3:0] prev;
      logic [3:0] exp_own[5];
      exp_own[0] = 4'b0001; exp_own[1] = 4'b0010; exp_own[2] = 4'b0100;
      exp_own[3] = 4'b1000; exp_own[4] = 4'b0001;
      do_reset();
      for (int r = 0; r < 4; r++) push_byte(r, 8'($urandom), 1'b1);
      push_byte(0, 8'($urandom), 1'b1);
      prev = 4'b0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (s_grant != 4'b0 && prev == 4'b0) begin
            own.push_back(s_grant);
            st.push_back(i);
         end
         prev = s_grant;
      end
      checks++; if (own.size() != 5) $display("FAIL rr_count got=%0d exp=5", own.size()); else passed++;
      for (int i = 0; i < 5 && i < own.size(); i++) begin
         checks++; if (own[i] !== exp_own[i]) $display("FAIL rr_owner%0d got=%b exp=%b", i, own[i], exp_own[i]); else passed++;
         checks++; if (st[i] != 2 * i + 1) $display("FAIL rr_start%0d got=%0d exp=%0d", i, st[i], 2 * i + 1); else passed++;
      end
   endtask

   task automatic test_hold_lock();
      logic [7:0] exp_b[6];
      do_reset();
      for (int i = 0; i < 6; i++) exp_b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) push_byte(1, exp_b[i], i == 3);
      step();
      step();
      push_byte(2, exp_b[4], 1'b0);
      push_byte(2, exp_b[5], 1'b1);
      hold[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (s_grant !== 4'b0010) $display("FAIL hold_grant%0d got=%b exp=0010", i, s_grant); else passed++;
      end
      hold[1] = 1'b0;
      repeat (12) step();
      checks++; if (wr_q.size() != 6) $display("FAIL hold_count got=%0d exp=6", wr_q.size()); else passed++;
      for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_b[i]) $display("FAIL hold_byte%0d got=%h exp=%h", i, wr_q[i], exp_b[i]); else passed++;
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] exp_b[3];
      int         nwe;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp_b[i] = 8'($urandom);
         push_byte(0, exp_b[i], i == 2);
      end
      step();
      step();
      full = 1'b1;
      nwe  = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (s_we === 1'b1) nwe++;
         checks++; if (s_ready !== 4'b0) $display("FAIL full_ready%0d got=%b exp=0000", i, s_ready); else passed++;
      end
      checks++; if (nwe != 1) $display("FAIL full_strobes got=%0d exp=1", nwe); else passed++;
      full = 1'b0;
      step();
      checks++; if (s_ready !== 4'b0001) $display("FAIL full_resume got=%b exp=0001", s_ready); else passed++;
      repeat (4) step();
      checks++; if (wr_q.size() != 3) $display("FAIL full_count got=%0d exp=3", wr_q.size()); else passed++;
      for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_b[i]) $display("FAIL full_byte%0d got=%h exp=%h", i, wr_q[i], exp_b[i]); else passed++;
      end
   endtask

   task automatic test_watchdog();
      int n;
      do_reset();
      push_byte(3, 8'hB0, 1'b0);
      push_byte(3, 8'hB1, 1'b1);
      step();
      hold[3] = 1'b1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (s_busy === 1'b1) n++;
         else break;
      end
      checks++; if (n != SL) $display("FAIL wd_lock_cycles got=%0d exp=%0d", n, SL); else passed++;
      checks++; if (s_err !== 1'b1) $display("FAIL wd_err got=%b exp=1", s_err); else passed++;
      checks++; if (s_src !== 2'd3) $display("FAIL wd_src got=%0d exp=3", s_src); else passed++;
      push_byte(0, 8'h3C, 1'b1);
      hold[3] = 1'b0;
      step();
      step();
      checks++; if (s_grant !== 4'b0001) $display("FAIL wd_next_grant got=%b exp=0001", s_grant); else passed++;
      step();
      hold[3] = 1'b1;
      step();
      checks++; if (s_grant !== 4'b1000) $display("FAIL wd_regrant got=%b exp=1000", s_grant); else passed++;
      repeat (SL - 2) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      checks++; if (s_err !== 1'b1) $display("FAIL wd_abort_wins got=%b exp=1", s_err); else passed++;
      checks++; if (s_grant !== 4'b0) $display("FAIL wd_abort2_grant got=%b exp=0000", s_grant); else passed++;
      hold[3] = 1'b0;
      pq[3].delete();
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      checks++; if (s_err !== 1'b0) $display("FAIL wd_clear got=%b exp=0", s_err); else passed++;
      checks++; if (s_src !== 2'd3) $display("FAIL wd_src_kept got=%0d exp=3", s_src); else passed++;
   endtask

   task automatic test_reset_midflight();
      do_reset();
      push_byte(0, 8'h77, 1'b1);
      step();
      step();
      push_byte(2, 8'hC1, 1'b0);
      push_byte(2, 8'hC2, 1'b1);
      step();
      // Grant cycle for req2 with a live handshake; reset lands before the edge.
      drive();
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #2;
      checks++; if (we !== 1'b0) $display("FAIL mid_we got=%b exp=0", we); else passed++;
      checks++; if (grant !== 4'b0) $display("FAIL mid_grant got=%b exp=0000", grant); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passed++;
      checks++; if (req_ready !== 4'b0) $display("FAIL mid_ready got=%b exp=0000", req_ready); else passed++;
      checks++; if (wdata !== 8'h00) $display("FAIL mid_wdata got=%h exp=00", wdata); else passed++;
      rst_i = 1'b0;
      model_reset();
      push_byte(0, 8'h78, 1'b1);
      step();
      step();
      checks++; if (s_grant !== 4'b0001) $display("FAIL mid_restart got=%b exp=0001", s_grant); else passed++;
      repeat (8) step();
   endtask

   task automatic test_random();
      int total;
      int len;
      int left;
      bool_loop: begin end
      do_reset();
      total = 0;
      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p < $urandom_range(1, 3); p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
               push_byte(r, 8'($urandom), b == len - 1);
               total++;
            end
         end
      end
      for (int k = 0; k < 3000; k++) begin
         left = 0;
         for (int r = 0; r < 4; r++) left += pq[r].size();
         if (left == 0 && exp_grant == 4'b0) break;
         full = ($urandom_range(0, 9) < 2);
         for (int r = 0; r < 4; r++) hold[r] = ($urandom_range(0, 9) == 0);
         clr = ($urandom_range(0, 19) == 0);
         step();
      end
      full = 1'b0;
      clr  = 1'b0;
      for (int r = 0; r < 4; r++) hold[r] = 1'b0;
      repeat (2) step();
      left = 0;
      for (int r = 0; r < 4; r++) left += pq[r].size();
      checks++; if (left != 0) $display("FAIL rand_drained got=%0d exp=0", left); else passed++;
      checks++; if (wr_q.size() != total) $display("FAIL rand_bytes got=%0d exp=%0d", wr_q.size(), total); else passed++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_packet();
      test_rr_order();
      test_hold_lock();
      test_fifo_full();
      test_watchdog();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
